imem_program_feeder: RTL and testbench



---
 rtl/imem_program_feeder.sv | 194 +++++++++++++++++++
 tb/tb_imem_program_feeder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_feeder.sv
// imem_program_feeder: writable program store streamed word-by-word over a
// valid/ready handshake, with NOP fill when idle, optional looping, and a
// saturating count of accepted words.
module imem_program_feeder #(
  parameter int                   DEPTH     = 16,
  parameter int                   WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] NOP       = 32'h00000013
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_load_en,
  input  logic [$clog2(DEPTH)-1:0]   i_load_addr,
  input  logic [WORD_SIZE-1:0]       i_load_data,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic                       i_loop_mode,
  input  logic [$clog2(DEPTH):0]     i_prog_len,
  input  logic                       i_resp_ready,
  output logic                       o_resp_valid,
  output logic [WORD_SIZE-1:0]       o_resp_data,
  output logic [WORD_SIZE-1:0]       o_resp_pc,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [15:0]                o_instr_count
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_LEN = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Program store has no reset so contents survive reset_n.
  logic [WORD_SIZE-1:0] r_mem [DEPTH];

  state_t               r_state;
  state_t               w_state_nx;
  logic [AW-1:0]        r_ptr;
  logic [AW-1:0]        w_ptr_nx;
  logic [AW:0]          r_len;
  logic [AW:0]          w_len_nx;
  logic [AW:0]          w_len_sel;
  logic [15:0]          r_count;
  logic [15:0]          w_count_nx;
  logic                 r_done;
  logic                 w_done_nx;
  logic                 w_fire;
  logic                 w_last;
  logic                 w_wr_en;
  logic [WORD_SIZE-1:0] w_rd_word;

  logic                 r_resp_valid;
  logic [WORD_SIZE-1:0] r_resp_data;
  logic [WORD_SIZE-1:0] r_resp_pc;

  assign w_fire  = r_resp_valid & i_resp_ready;
  assign w_last  = ({1'b0, r_ptr} == (r_len - {{AW{1'b0}}, 1'b1}));
  assign w_wr_en = i_load_en & (r_state != ST_STREAM);

  // Clamp the requested length: zero or oversize means the whole store.
  always_comb begin
    w_len_sel = FULL_LEN;
    if ((i_prog_len == {(AW+1){1'b0}}) || (i_prog_len > FULL_LEN)) begin
      w_len_sel = FULL_LEN;
    end else begin
      w_len_sel = i_prog_len;
    end
  end

  // Next-state, pointer, length, count and done computation.
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_len_nx   = r_len;
    w_count_nx = r_count;
    w_done_nx  = r_done;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state_nx = ST_STREAM;
          w_ptr_nx   = {AW{1'b0}};
          w_len_nx   = w_len_sel;
          w_count_nx = 16'd0;
          w_done_nx  = 1'b0;
        end else if (i_abort) begin
          w_state_nx = ST_IDLE;
          w_ptr_nx   = {AW{1'b0}};
          w_done_nx  = 1'b0;
        end else begin
          w_state_nx = r_state;
        end
      end
      ST_STREAM: begin
        if (i_abort) begin
          // Abort wins over a same-cycle handshake: nothing is counted.
          w_state_nx = ST_IDLE;
          w_ptr_nx   = {AW{1'b0}};
          w_done_nx  = 1'b0;
        end else if (w_fire) begin
          if (r_count == 16'hFFFF) begin
            w_count_nx = r_count;
          end else begin
            w_count_nx = r_count + 16'd1;
          end
          if (!w_last) begin
            w_ptr_nx = r_ptr + AW'(1'b1);
          end else if (i_loop_mode) begin
            w_ptr_nx = {AW{1'b0}};
          end else begin
            w_state_nx = ST_DONE;
            w_ptr_nx   = {AW{1'b0}};
            w_done_nx  = 1'b1;
          end
        end else begin
          w_ptr_nx = r_ptr;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_ptr_nx   = {AW{1'b0}};
        w_done_nx  = 1'b0;
      end
    endcase
  end

  // Word presented next: a same-edge write to that slot bypasses the store.
  always_comb begin
    w_rd_word = r_mem[w_ptr_nx];
    if (w_wr_en && (i_load_addr == w_ptr_nx)) begin
      w_rd_word = i_load_data;
    end else begin
      w_rd_word = r_mem[w_ptr_nx];
    end
  end

  // Program store write port; writes are locked out while streaming.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[i_load_addr] <= i_load_data;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Datapath registers: pointer, latched length, count and done flag.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_ptr   <= {AW{1'b0}};
      r_len   <= FULL_LEN;
      r_count <= 16'd0;
      r_done  <= 1'b0;
    end else begin
      r_ptr   <= w_ptr_nx;
      r_len   <= w_len_nx;
      r_count <= w_count_nx;
      r_done  <= w_done_nx;
    end
  end

  // Registered response: word and byte address in STREAM, NOP and 0 otherwise.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= NOP;
      r_resp_pc    <= {WORD_SIZE{1'b0}};
    end else if (w_state_nx == ST_STREAM) begin
      r_resp_valid <= 1'b1;
      r_resp_data  <= w_rd_word;
      r_resp_pc    <= WORD_SIZE'({w_ptr_nx, 2'b00});
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= NOP;
      r_resp_pc    <= {WORD_SIZE{1'b0}};
    end
  end

  assign o_resp_valid  = r_resp_valid;
  assign o_resp_data   = r_resp_data;
  assign o_resp_pc     = r_resp_pc;
  assign o_busy        = r_resp_valid;
  assign o_done        = r_done;
  assign o_instr_count = r_count;

endmodule

// File: tb/tb_imem_program_feeder.sv
// Scoreboard bench for imem_program_feeder: the driver pushes the expected
// word/pc stream when it starts a pass; a negedge monitor compares every
// presented word against the queue head and pops on each handshake.
module tb_imem_program_feeder;

  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [31:0] load_data;
  logic        start;
  logic        abort;
  logic        loop_mode;
  logic [4:0]  prog_len;
  logic        resp_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [31:0] resp_pc;
  logic        busy;
  logic        done;
  logic [15:0] instr_count;

  int          n_checks = 0;
  int          n_pass   = 0;
  bit          mon_en   = 1'b0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_data [$];
  logic [31:0] exp_pc [$];

  always #5 clk = ~clk;

  imem_program_feeder #(.DEPTH(DEPTH), .WORD_SIZE(32), .NOP(NOP)) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_load_en     (load_en),
    .i_load_addr   (load_addr),
    .i_load_data   (load_data),
    .i_start       (start),
    .i_abort       (abort),
    .i_loop_mode   (loop_mode),
    .i_prog_len    (prog_len),
    .i_resp_ready  (resp_ready),
    .o_resp_valid  (resp_valid),
    .o_resp_data   (resp_data),
    .o_resp_pc     (resp_pc),
    .o_busy        (busy),
    .o_done        (done),
    .o_instr_count (instr_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_len(input int l);
    return ((l == 0) || (l > DEPTH)) ? DEPTH : l;
  endfunction

  task automatic flush();
    exp_data.delete();
    exp_pc.delete();
  endtask

  task automatic do_load(input int addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = addr[3:0];
    load_data = data;
    ref_mem[addr] = data;
    tick();
    load_en = 1'b0;
  endtask

  // Queue the expected stream (index wraps modulo the effective length), then start.
  task automatic start_pass(input int len, input int words);
    int n;
    n = eff_len(len);
    for (int k = 0; k < words; k++) begin
      exp_data.push_back(ref_mem[k % n]);
      exp_pc.push_back(32'((k % n) * 4));
    end
    prog_len = len[4:0];
    start    = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_ready);
    for (int c = 0; c < budget; c++) begin
      if (done) break;
      if (rand_ready) resp_ready = 1'($urandom % 2);
      tick();
    end
    chk("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic check_idle(input string tag, input logic [15:0] cnt, input logic dn);
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_data"},  resp_data, NOP);
    chk({tag, "_pc"},    resp_pc, 32'd0);
    chk({tag, "_done"},  {31'd0, done}, {31'd0, dn});
    chk({tag, "_count"}, {16'd0, instr_count}, {16'd0, cnt});
  endtask

  // Monitor: every valid word must match the queue head; pop on handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      if (resp_valid) begin
        chk("expect_pending", {31'd0, exp_data.size() != 0}, 32'd1);
        if (exp_data.size() != 0) begin
          chk("resp_data", resp_data, exp_data[0]);
          chk("resp_pc", resp_pc, exp_pc[0]);
          if (resp_ready) begin
            void'(exp_data.pop_front());
            void'(exp_pc.pop_front());
          end
        end
      end else begin
        chk("nop_fill", resp_data, NOP);
        chk("idle_pc", resp_pc, 32'd0);
      end
    end
  end

  initial begin
    bit bp_pat [7];
    int len;
    logic [31:0] w;
    bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    reset_n = 1'b0; load_en = 1'b0; load_addr = 4'd0; load_data = 32'd0;
    start = 1'b0; abort = 1'b0; loop_mode = 1'b0; prog_len = 5'd0; resp_ready = 1'b0;
    tick(); tick();
    check_idle("reset", 16'd0, 1'b0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Basic pass over the full store.
    for (int i = 0; i < DEPTH; i++) do_load(i, 32'h00100093 + 32'(i));
    resp_ready = 1'b1;
    start_pass(16, 16);
    wait_done(40, 1'b0);
    chk("basic_count", {16'd0, instr_count}, 32'd16);
    chk("basic_data_nop", resp_data, NOP);
    chk("basic_valid", {31'd0, resp_valid}, 32'd0);
    chk("basic_drained", exp_data.size(), 32'd0);

    // Fixed backpressure pattern on a 4-word program.
    start_pass(4, 4);
    for (int c = 0; c < 7; c++) begin
      resp_ready = bp_pat[c];
      tick();
    end
    chk("bp_done", {31'd0, done}, 32'd1);
    chk("bp_count", {16'd0, instr_count}, 32'd4);
    chk("bp_drained", exp_data.size(), 32'd0);

    // Randomised contents, lengths and backpressure.
    for (int p = 0; p < 6; p++) begin
      repeat (4) do_load(int'($urandom % DEPTH), $urandom);
      len = int'($urandom_range(0, 20));
      start_pass(len, eff_len(len));
      wait_done(400, 1'b1);
      chk("rand_count", {16'd0, instr_count}, 32'(eff_len(len)));
      chk("rand_drained", exp_data.size(), 32'd0);
    end

    // Loop/wrap, then drop loop_mode to stop after the next last word.
    resp_ready = 1'b1;
    loop_mode  = 1'b1;
    start_pass(3, 12);
    repeat (10) tick();
    chk("loop_done_low", {31'd0, done}, 32'd0);
    chk("loop_count10", {16'd0, instr_count}, 32'd10);
    loop_mode = 1'b0;
    wait_done(20, 1'b0);
    chk("loop_count12", {16'd0, instr_count}, 32'd12);
    chk("loop_drained", exp_data.size(), 32'd0);

    // Length clamp.
    start_pass(0, 16);
    wait_done(40, 1'b0);
    chk("clamp0_count", {16'd0, instr_count}, 32'd16);
    start_pass(17, 16);
    wait_done(40, 1'b0);
    chk("clamp17_count", {16'd0, instr_count}, 32'd16);

    // Reset mid-stream at word 5; store must survive.
    start_pass(16, 16);
    repeat (5) tick();
    resp_ready = 1'b0;
    reset_n    = 1'b0;
    tick();
    flush();
    check_idle("midreset", 16'd0, 1'b0);
    reset_n    = 1'b1;
    resp_ready = 1'b1;
    start_pass(16, 16);
    wait_done(40, 1'b0);
    chk("restart_count", {16'd0, instr_count}, 32'd16);

    // Load lockout while streaming.
    resp_ready = 1'b0;
    start_pass(8, 8);
    w = ~ref_mem[2];
    load_en = 1'b1; load_addr = 4'd2; load_data = w;
    tick();
    load_en    = 1'b0;
    resp_ready = 1'b1;
    wait_done(40, 1'b0);
    start_pass(8, 8);
    wait_done(40, 1'b0);
    chk("lockout_drained", exp_data.size(), 32'd0);

    // Simultaneous start and write to slot 0 from DONE.
    load_en = 1'b1; load_addr = 4'd0; load_data = 32'hCAFE0013;
    ref_mem[0] = 32'hCAFE0013;
    start_pass(4, 4);
    load_en = 1'b0;
    wait_done(40, 1'b0);
    chk("bypass_drained", exp_data.size(), 32'd0);

    // Abort after three accepted words, with ready high on the abort edge.
    start_pass(16, 16);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    flush();
    check_idle("abort", 16'd3, 1'b0);
    repeat (2) tick();
    chk("abort_frozen", {16'd0, instr_count}, 32'd3);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
